// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select and load size.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_WORD   = 2'd0,
    LD_BYTE_U = 2'd1,
    LD_BYTE_S = 2'd2,
    LD_RSVD   = 2'd3
  } ld_size_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational sub-word load alignment: picks one byte lane and zero- or
// sign-extends it, or passes the whole word through.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BSEL_W = $clog2(WIDTH/8)
) (
  input  logic [WIDTH-1:0]  MemOut,
  input  logic [1:0]        MemSize,
  input  logic [BSEL_W-1:0] ByteSel,
  output logic [WIDTH-1:0]  AlignedData
);

  localparam int NLANES = WIDTH / 8;

  logic [7:0] lanes [NLANES];
  logic [7:0] lane;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign lanes[gi] = MemOut[8*gi +: 8];
  end

  // A select beyond the last lane (non power-of-two byte counts) reads as zero.
  always_comb begin
    lane = 8'h00;
    for (int i = 0; i < NLANES; i++) begin
      if (ByteSel == BSEL_W'(i)) lane = lanes[i];
    end
  end

  always_comb begin
    AlignedData = MemOut;
    case (ld_size_e'(MemSize))
      LD_BYTE_U: AlignedData = {{(WIDTH-8){1'b0}}, lane};
      LD_BYTE_S: AlignedData = {{(WIDTH-8){lane[7]}}, lane};
      default:   AlignedData = MemOut;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: result select, stage register toward the register file,
// a combinational forwarding tap, and a retired-instruction counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REG_AW   = 3,
  parameter int CNT_W    = 32,
  parameter int ZERO_REG = 0,
  parameter int BSEL_W   = $clog2(WIDTH/8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic              InRegWrite,
  input  logic [REG_AW-1:0] InRegAddr,
  input  logic [1:0]        WBSel,
  input  logic [1:0]        MemSize,
  input  logic [BSEL_W-1:0] ByteSel,
  input  logic [WIDTH-1:0]  ALUOut,
  input  logic [WIDTH-1:0]  MemOut,
  input  logic [WIDTH-1:0]  LinkIn,
  input  logic [WIDTH-1:0]  ImmIn,
  output logic              FwdValid,
  output logic [REG_AW-1:0] FwdAddr,
  output logic [WIDTH-1:0]  FwdData,
  output logic              WBValid,
  output logic              WBRegWrite,
  output logic [REG_AW-1:0] WBRegAddr,
  output logic [WIDTH-1:0]  WBData,
  output logic [CNT_W-1:0]  RetireCount
);

  logic [WIDTH-1:0]  load_data;
  logic [WIDTH-1:0]  result;
  logic              eff_write;
  logic              zero_block;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_write_q, wb_write_d;
  logic [REG_AW-1:0] wb_addr_q,  wb_addr_d;
  logic [WIDTH-1:0]  wb_data_q,  wb_data_d;
  logic [CNT_W-1:0]  retire_q,   retire_d;

  wb_load_align #(.WIDTH(WIDTH), .BSEL_W(BSEL_W)) u_align (
    .MemOut      (MemOut),
    .MemSize     (MemSize),
    .ByteSel     (ByteSel),
    .AlignedData (load_data)
  );

  always_comb begin
    result = ALUOut;
    case (wb_sel_e'(WBSel))
      WB_ALU:  result = ALUOut;
      WB_MEM:  result = load_data;
      WB_LINK: result = LinkIn;
      WB_IMM:  result = ImmIn;
    endcase
  end

  assign zero_block = (ZERO_REG != 0) && (InRegAddr == '0);
  assign eff_write  = InValid & InRegWrite & ~zero_block;

  // Forwarding tap sees the incoming instruction regardless of Stall.
  assign FwdValid = eff_write & ~Flush;
  assign FwdAddr  = InRegAddr;
  assign FwdData  = result;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_write_d = wb_write_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    retire_d   = retire_q;
    if (Flush) begin
      // Bubble: address and data are held, only the qualifiers drop.
      wb_valid_d = 1'b0;
      wb_write_d = 1'b0;
    end else if (!Stall) begin
      wb_valid_d = InValid;
      wb_write_d = eff_write;
      wb_addr_d  = InRegAddr;
      wb_data_d  = result;
      if (InValid) retire_d = retire_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      retire_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
    end
  end

  assign WBValid     = wb_valid_q;
  assign WBRegWrite  = wb_write_q;
  assign WBRegAddr   = wb_addr_q;
  assign WBData      = wb_data_q;
  assign RetireCount = retire_q;

endmodule
